// File: rtl/float_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : float_params (package)
// Description : Float datapath widths and divider state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package float_params;

    localparam int float_width      = 32;
    localparam int float_exp_width  = 8;
    localparam int float_mant_width = 23;
    localparam int float_exp_bias   = 127;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2
    } float_div_state_e;

endpackage
`default_nettype wire

// File: rtl/float_div_mant.sv
`default_nettype none
// ============================================================================
// Module      : float_div_mant
// Description : Restoring mantissa divider, one quotient bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module float_div_mant
    import float_params::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [float_mant_width:0]   dividend,
    input  logic [float_mant_width:0]   divisor,
    output logic [float_mant_width+1:0] q,
    output logic                        done
);

    localparam int          QW          = float_mant_width + 2;
    localparam logic [4:0]  C_LAST_ITER = 5'(QW - 1);

    logic [QW-1:0]            r_rem;
    logic [QW-1:0]            r_q;
    logic [float_mant_width:0] r_div;
    logic [4:0]               r_cnt;
    logic                     r_active;

    logic                     w_ge;
    logic [QW-1:0]            w_diff;

    // rem < 2*div always holds, so the shifted remainder never loses its MSB
    assign w_ge   = (r_rem >= {1'b0, r_div});
    assign w_diff = r_rem - {1'b0, r_div};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem    <= '0;
            r_q      <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_rem    <= {1'b0, dividend};
            r_div    <= divisor;
            r_q      <= '0;
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (w_ge) begin
                r_rem <= {w_diff[QW-2:0], 1'b0};
                r_q   <= {r_q[QW-2:0], 1'b1};
            end else begin
                r_rem <= {r_rem[QW-2:0], 1'b0};
                r_q   <= {r_q[QW-2:0], 1'b0};
            end
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == C_LAST_ITER) begin
                r_active <= 1'b0;
            end
        end
    end

    assign q    = r_q;
    assign done = r_active && (r_cnt == C_LAST_ITER);

endmodule
`default_nettype wire

// File: rtl/float_div.sv
`default_nettype none
// ============================================================================
// Module      : float_div
// Description : Iterative single-precision divider (truncating, no denormals).
// Revision    : 1.0 - initial release
// ============================================================================
module float_div
    import float_params::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic [float_width-1:0] a,
    input  logic [float_width-1:0] b,
    output logic                   busy,
    output logic                   ack,
    output logic [float_width-1:0] out
);

    localparam logic signed [9:0] C_EXP_MAX = 10'sd255;
    localparam logic signed [9:0] C_EXP_MIN = 10'sd0;

    float_div_state_e              r_state;
    logic                          r_busy;
    logic                          r_ack;
    logic [float_width-1:0]        r_out;
    logic                          r_sign;
    logic signed [9:0]             r_exp_raw;

    logic                          w_a_sign;
    logic                          w_b_sign;
    logic [float_exp_width-1:0]    w_a_exp;
    logic [float_exp_width-1:0]    w_b_exp;
    logic [float_mant_width-1:0]   w_a_mant;
    logic [float_mant_width-1:0]   w_b_mant;
    logic                          w_sign;
    logic                          w_start;
    logic signed [9:0]             w_exp_raw;
    logic [float_mant_width+1:0]   w_q;
    logic                          w_done;
    logic [float_mant_width-1:0]   w_norm_mant;
    logic signed [9:0]             w_norm_exp;
    logic [float_width-1:0]        w_norm_out;

    assign {w_a_sign, w_a_exp, w_a_mant} = a;
    assign {w_b_sign, w_b_exp, w_b_mant} = b;
    assign w_sign    = w_a_sign ^ w_b_sign;
    assign w_start   = (r_state == IDLE) && req && (w_a_exp != '0) && (w_b_exp != '0);
    assign w_exp_raw = {2'b00, w_a_exp} - {2'b00, w_b_exp} + 10'(float_exp_bias);

    float_div_mant u_mant (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .dividend ({1'b1, w_a_mant}),
        .divisor  ({1'b1, w_b_mant}),
        .q        (w_q),
        .done     (w_done)
    );

    // Quotient in (0.5, 2): q[24] set means no left-normalisation needed
    always_comb begin
        w_norm_mant = w_q[float_mant_width+1] ? w_q[float_mant_width:1]
                                              : w_q[float_mant_width-1:0];
        w_norm_exp  = w_q[float_mant_width+1] ? r_exp_raw : (r_exp_raw - 10'sd1);
        w_norm_out  = {r_sign, w_norm_exp[float_exp_width-1:0], w_norm_mant};
        if (w_norm_exp <= C_EXP_MIN) begin
            w_norm_out = '0;
        end else if (w_norm_exp >= C_EXP_MAX) begin
            w_norm_out = {r_sign, {float_exp_width{1'b1}}, {float_mant_width{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_ack     <= 1'b0;
            r_out     <= '0;
            r_sign    <= 1'b0;
            r_exp_raw <= '0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        if (w_a_exp == '0) begin
                            r_out <= '0;
                            r_ack <= 1'b1;
                        end else if (w_b_exp == '0) begin
                            r_out <= {w_sign, {float_exp_width{1'b1}}, {float_mant_width{1'b0}}};
                            r_ack <= 1'b1;
                        end else begin
                            r_sign    <= w_sign;
                            r_exp_raw <= w_exp_raw;
                            r_busy    <= 1'b1;
                            r_state   <= DIV;
                        end
                    end
                end
                DIV: begin
                    if (w_done) begin
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    r_out   <= w_norm_out;
                    r_ack   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign ack  = r_ack;
    assign out  = r_out;

endmodule
`default_nettype wire

// File: tb/tb_float_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_float_div
// Description : Self-checking bench for float_div: vector table + scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_float_div;
    import float_params::*;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   req = 1'b0;
    logic [float_width-1:0] a   = '0;
    logic [float_width-1:0] b   = '0;
    logic                   busy;
    logic                   ack;
    logic [float_width-1:0] out;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    float_div dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .a    (a),
        .b    (b),
        .busy (busy),
        .ack  (ack),
        .out  (out)
    );

    typedef struct {
        string       name;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] vq;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Scoreboard: every ack consumes the oldest expected result
    always @(negedge clk) begin
        if (rst && ack) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected_ack: got ack with out=0x%08h expected no ack", out);
            end else begin
                check("sb_out", out, sb_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vq);
        a   = va;
        b   = vb;
        req = 1'b1;
        sb_q.push_back(vq);
    endtask

    // Returns at #1 after the ack edge; optionally pokes req mid-divide
    task automatic wait_ack(input string name, input int exp_lat, input bit junk);
        int lat = 0;
        bit got = 0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) req = 1'b0;
            if (ack) begin
                got = 1;
            end else begin
                check({name, "_busy"}, {31'b0, busy}, 32'd1);
                if (junk && (lat == 5 || lat == 20)) begin
                    req = 1'b1;
                    a   = $urandom;
                    b   = $urandom;
                end else if (junk && (lat == 6 || lat == 21)) begin
                    req = 1'b0;
                end
            end
        end
        if (got) begin
            check({name, "_lat"}, 32'(lat), 32'(exp_lat));
            check({name, "_busy_at_ack"}, {31'b0, busy}, 32'd0);
        end else begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got no ack in 40 cycles expected ack after %0d", name, exp_lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int saw_ack;

        vecs[0] = '{"div_6_2",      32'h40C00000, 32'h40000000, 32'h40400000, 27};
        vecs[1] = '{"div_1_3",      32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 27};
        vecs[2] = '{"div_m7p5_2p5", 32'hC0F00000, 32'h40200000, 32'hC0400000, 27};
        vecs[3] = '{"fast_a_zero",  32'h80000000, 32'h40000000, 32'h00000000, 1};
        vecs[4] = '{"fast_b_zero",  32'h3F800000, 32'h00000000, 32'h7F800000, 1};
        vecs[5] = '{"fast_neg_b0",  32'hBF800000, 32'h00000000, 32'hFF800000, 1};
        vecs[6] = '{"ovf_e256",     32'h7F000000, 32'h3E800000, 32'h7F800000, 27};
        vecs[7] = '{"unf_e0",       32'h00800000, 32'h40000000, 32'h00000000, 27};
        vecs[8] = '{"div_1_1",      32'h3F800000, 32'h3F800000, 32'h3F800000, 27};
        vecs[9] = '{"div_m1_m4",    32'hBF800000, 32'hC0800000, 32'h3E800000, 27};

        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_ack",  {31'b0, ack},  32'd0);
        check("rst_out",  out,           32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            issue(vecs[i].va, vecs[i].vb, vecs[i].vq);
            wait_ack(vecs[i].name, vecs[i].lat, 1'b0);
            check({vecs[i].name, "_out"}, out, vecs[i].vq);
        end

        // Requests while busy must be dropped and leave the result intact
        @(negedge clk);
        issue(32'h40C00000, 32'h40000000, 32'h40400000);
        wait_ack("ignore_req", 27, 1'b1);
        repeat (3) @(negedge clk);
        check("ignore_req_held", out, 32'h40400000);
        check("ignore_req_idle", {31'b0, busy}, 32'd0);

        // req held during the ack cycle is accepted immediately
        @(negedge clk);
        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAA);
        wait_ack("chain_first", 27, 1'b0);
        issue(32'hC0F00000, 32'h40200000, 32'hC0400000);
        wait_ack("chain_second", 27, 1'b0);
        check("chain_out", out, 32'hC0400000);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        issue(32'h40C00000, 32'h40000000, 32'h40400000);
        @(posedge clk);
        #1 req = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_ack",  {31'b0, ack},  32'd0);
        check("abort_out",  out,           32'd0);
        sb_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        saw_ack = 0;
        repeat (40) begin
            @(negedge clk);
            if (ack) saw_ack++;
        end
        check("abort_no_ack", 32'(saw_ack), 32'd0);

        @(negedge clk);
        issue(32'h40C00000, 32'h40000000, 32'h40400000);
        wait_ack("post_reset", 27, 1'b0);
        check("post_reset_out", out, 32'h40400000);

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/float_div.md
Name: float_div

Overview:
- Iterative single-precision float divider, `out = a / b`. It is the inverse-operation companion to the combinational `float_mul` in the GPU float datapath.
- Uses restoring mantissa division, one quotient bit per clock, under a req/busy/ack handshake.
- Numeric conventions match `float_mul`:
  - zero exponent means zero (no denormals);
  - result is truncated, not rounded;
  - exp=255 inputs are treated as ordinary normals, not inf/NaN.

Parameters:
- None at module level. All widths come from package `float_params`:
  - float_width, 32, total float bits
  - float_exp_width, 8, exponent bits
  - float_mant_width, 23, stored mantissa bits
  - float_exp_bias, 127, exponent bias

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  1  start request; sampled only when busy=0
- a  in  float_width  dividend; captured on the edge that accepts req
- b  in  float_width  divisor; captured with a
- busy  out  1  divide in progress; req ignored while high
- ack  out  1  one-cycle pulse; out valid from this cycle onward
- out  out  float_width  quotient; held until the next ack

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, busy=0, ack=0, out=0, internal counters/regs=0. Reset mid-divide aborts the operation; no ack is produced.
- ack defaults to 0 every cycle unless set as described below.
- IDLE, req=1 on edge N. Fields are unpacked as in float_mul; sign = a_sign ^ b_sign.
  - Fast path A, a_exp==0: out<=0x00000000 (sign forced 0), ack<=1 at edge N, stay IDLE.
  - Fast path B, a_exp!=0 and b_exp==0: out<={sign, 8'hFF, 23'b0}, ack<=1 at edge N, stay IDLE.
  - Otherwise:
    - rem<={1'b0, 1, a_mant}, 25 bits;
    - div<={1, b_mant};
    - q<=0; cnt<=0;
    - exp_raw<=a_exp - b_exp + 127, signed 10-bit;
    - state<=DIV, busy<=1.
- DIV, one iteration per edge for 25 edges (N+1..N+25):
  - if rem >= div: rem<=(rem-div)<<1 and q<={q[23:0],1};
  - else: rem<=rem<<1 and q<={q[23:0],0};
  - cnt++; on cnt==24, state<=NORM.
  - q[24] has weight 2^0 and q[0] has weight 2^-24. Quotient lies in (0.5, 2).
- NORM, edge N+26:
  - if q[24]: mant=q[23:1], e=exp_raw;
  - else: mant=q[22:0], e=exp_raw-1.
  - if e<=0: out<=0x00000000 (underflow flush, sign 0).
  - else if e>=255: out<={sign, 8'hFF, 23'b0}.
  - else: out<={sign, e[7:0], mant}.
  - ack<=1, busy<=0, state<=IDLE.
- Latency: normal path, ack is high in the cycle after edge N+26; fast path, in the cycle after edge N.
- Throughput and req timing:
  - A req high during the ack cycle is accepted (busy=0 then). Back-to-back ops therefore take 27 cycles each.
  - req while busy=1 is dropped: no queueing, and a/b must not corrupt the in-flight op.
- out changes only on an edge that asserts ack (or on reset).
- Remainder invariant: rem < 2*div at every iteration, so 25 bits suffice and there is no overflow.
- Undefined (X) a/b while req=0 must not affect state.

Decomposition:
- Package `float_params`: float_width, float_exp_width, float_mant_width, float_exp_bias; state enum `float_div_state_e` {IDLE, DIV, NORM}. float_mul imports the same package.
- One sub-module: `float_div_mant`, the 24-bit iterative restoring mantissa divider.
  - Inputs: clk, rst, start, dividend, divisor.
  - Outputs: 25-bit q, done.
  - Top level keeps the exponent/sign/special-case logic and the handshake.

Test Plan:
- 6.0/2.0: a=0x40C00000, b=0x40000000 → out=0x40400000; ack exactly 26 edges after the accepting edge; busy high throughout.
- 1.0/3.0: a=0x3F800000, b=0x40400000 → 0x3EAAAAAA (truncated, not 0x3EAAAAAB). Also -7.5/2.5: 0xC0F00000/0x40200000 → 0xC0400000.
- Fast paths, ack 1 edge after req:
  - a=0x80000000 (exp 0) → 0x00000000;
  - a=0x3F800000, b=0 → 0x7F800000;
  - a=0xBF800000, b=0 → 0xFF800000.
- Range:
  - 0x7F000000/0x3E800000 → 0x7F800000 (e=256, overflow);
  - 0x00800000/0x40000000 → 0x00000000 (e=0, underflow flush);
  - 0x3F800000/0x3F800000 → 0x3F800000.
- Handshake: pulse req with different a/b at cycles 5 and 20 of a divide → ignored, first result unchanged. req asserted in the ack cycle → accepted, second result correct.
- Reset: drop rst at cycle 10 of a divide → busy=0, ack=0, out=0 immediately (async), no later ack. A fresh 6.0/2.0 after release → 0x40400000.
